// File: rtl/ps2_direction_ctrl_if.sv
// PS/2 byte stream in, Pac-Man direction/pause commands out.
// Latency: none (bundle of wires only).
// Backpressure: none; the byte strobe is fire-and-forget.
interface ps2_direction_ctrl_if;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic       goup;
  logic       godown;
  logic       goleft;
  logic       goright;
  logic       dir_change;
  logic [3:0] key_held;
  logic       paused;

  // Byte source side (PS2_Controller or bench)
  modport master (
    output ps2_data, ps2_data_en,
    input  goup, godown, goleft, goright, dir_change, key_held, paused
  );

  // Decoder side
  modport slave (
    input  ps2_data, ps2_data_en,
    output goup, godown, goleft, goright, dir_change, key_held, paused
  );
endinterface

// File: rtl/ps2_direction_ctrl.sv
// Decodes PS/2 make/break bytes (incl. E0 arrows) into a latched one-hot move command.
// Latency: byte strobed in cycle N appears on the registered outputs in cycle N+1.
// Backpressure: none; one byte accepted every cycle, prefix states abort on timeout.
module ps2_direction_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic           CLOCK_50,
  input logic           resetn,
  ps2_direction_ctrl_if.slave bus
);

  localparam logic [7:0]  LP_E0       = 8'hE0;
  localparam logic [7:0]  LP_F0       = 8'hF0;
  localparam logic [19:0] LP_TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GOT_E0   = 2'd1,
    S_GOT_F0   = 2'd2,
    S_GOT_E0F0 = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic [19:0] r_cnt, w_cnt_nxt;
  // Direction vectors are ordered {up,down,left,right}, matching key_held.
  logic [3:0]  r_dir, w_dir_nxt;
  logic [3:0]  r_held, w_held_nxt;
  logic        r_dir_chg, w_dir_chg_nxt;
  logic        r_paused, w_paused_nxt;
  logic        r_p_down, w_p_down_nxt;

  logic        w_is_brk;
  logic        w_dir_hit;
  logic [3:0]  w_dir_oh;
  logic        w_p_hit;
  logic        w_esc_hit;

  // Reset asserts immediately, releases two clocks after resetn rises
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Classify the incoming byte in the context of the current prefix state
  always_comb begin
    w_dir_hit = 1'b0;
    w_dir_oh  = 4'b0000;
    w_p_hit   = 1'b0;
    w_esc_hit = 1'b0;
    w_is_brk  = (r_state == S_GOT_F0) || (r_state == S_GOT_E0F0);
    if ((r_state == S_IDLE) || (r_state == S_GOT_F0)) begin
      case (bus.ps2_data)
        8'h1D:   begin w_dir_hit = 1'b1; w_dir_oh = 4'b1000; end
        8'h1B:   begin w_dir_hit = 1'b1; w_dir_oh = 4'b0100; end
        8'h1C:   begin w_dir_hit = 1'b1; w_dir_oh = 4'b0010; end
        8'h23:   begin w_dir_hit = 1'b1; w_dir_oh = 4'b0001; end
        8'h4D:   w_p_hit   = 1'b1;
        8'h76:   w_esc_hit = 1'b1;
        default: ;
      endcase
    end else begin
      case (bus.ps2_data)
        8'h75:   begin w_dir_hit = 1'b1; w_dir_oh = 4'b1000; end
        8'h72:   begin w_dir_hit = 1'b1; w_dir_oh = 4'b0100; end
        8'h6B:   begin w_dir_hit = 1'b1; w_dir_oh = 4'b0010; end
        8'h74:   begin w_dir_hit = 1'b1; w_dir_oh = 4'b0001; end
        default: ;
      endcase
    end
  end

  // Next-state and next-output logic; a strobe always beats the timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dir_nxt     = r_dir;
    w_dir_chg_nxt = 1'b0;
    w_held_nxt    = r_held;
    w_paused_nxt  = r_paused;
    w_p_down_nxt  = r_p_down;
    if (bus.ps2_data_en) begin
      w_cnt_nxt = '0;
      if (bus.ps2_data == LP_E0) begin
        // E0 restarts an extended sequence and drops any pending break
        w_state_nxt = S_GOT_E0;
      end else if (bus.ps2_data == LP_F0) begin
        if (r_state == S_IDLE)        w_state_nxt = S_GOT_F0;
        else if (r_state == S_GOT_E0) w_state_nxt = S_GOT_E0F0;
      end else begin
        w_state_nxt = S_IDLE;
        if (w_dir_hit) begin
          if (w_is_brk) begin
            // Releasing a key leaves Pac-Man moving in the latched direction
            w_held_nxt = r_held & ~w_dir_oh;
          end else begin
            w_held_nxt = r_held | w_dir_oh;
            if (r_dir != w_dir_oh) begin
              w_dir_nxt     = w_dir_oh;
              w_dir_chg_nxt = 1'b1;
            end
          end
        end else if (w_p_hit) begin
          // Typematic repeats of P toggle only once until P is released
          if (w_is_brk) begin
            w_p_down_nxt = 1'b0;
          end else if (!r_p_down) begin
            w_paused_nxt = ~r_paused;
            w_p_down_nxt = 1'b1;
          end
        end else if (w_esc_hit && !w_is_brk) begin
          w_dir_nxt     = 4'b0000;
          w_dir_chg_nxt = |r_dir;
        end
      end
    end else if (r_state != S_IDLE) begin
      if (r_cnt == LP_TMO_LAST) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 20'd1;
      end
    end
  end

  // Decoder state register
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Timeout counter, command, held-key and pause registers
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt     <= '0;
      r_dir     <= 4'b0000;
      r_dir_chg <= 1'b0;
      r_held    <= 4'b0000;
      r_paused  <= 1'b0;
      r_p_down  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_dir_chg <= w_dir_chg_nxt;
      r_held    <= w_held_nxt;
      r_paused  <= w_paused_nxt;
      r_p_down  <= w_p_down_nxt;
    end
  end

  assign bus.goup       = r_dir[3];
  assign bus.godown     = r_dir[2];
  assign bus.goleft     = r_dir[1];
  assign bus.goright    = r_dir[0];
  assign bus.dir_change = r_dir_chg;
  assign bus.key_held   = r_held;
  assign bus.paused     = r_paused;

endmodule

// File: tb/tb_ps2_direction_ctrl.sv
// Bench for ps2_direction_ctrl: directed plan plus random byte streams vs. a key-event model.
// Latency: outputs compared #1 after every clock edge against the model.
// Backpressure: none; bytes are strobed whenever the bench chooses.
module tb_ps2_direction_ctrl;
  localparam int T = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ps2_direction_ctrl_if bus();

  ps2_direction_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: latched direction as an index (-1 none, 0 up, 1 down, 2 left, 3 right)
  int m_dir;
  bit m_held [4];
  bit m_paused, m_p_down, m_chg;
  bit m_e0, m_f0;
  int m_last;

  logic [7:0] pool [0:15] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                              8'h4D, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hAA, 8'hFA};

  function automatic int plain_act(input logic [7:0] b);
    case (b)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      8'h4D: return 4;
      8'h76: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int ext_act(input logic [7:0] b);
    case (b)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_clear();
    m_dir = -1;
    for (int k = 0; k < 4; k++) m_held[k] = 1'b0;
    m_paused = 1'b0; m_p_down = 1'b0; m_chg = 1'b0;
    m_e0 = 1'b0; m_f0 = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int act;
    bit brk;
    // A prefix older than T cycles has been abandoned
    if (cyc - m_last > T) begin m_e0 = 1'b0; m_f0 = 1'b0; end
    m_last = cyc;
    if (b == 8'hE0) begin
      m_e0 = 1'b1; m_f0 = 1'b0;
    end else if (b == 8'hF0) begin
      m_f0 = 1'b1;
    end else begin
      act = m_e0 ? ext_act(b) : plain_act(b);
      brk = m_f0;
      m_e0 = 1'b0; m_f0 = 1'b0;
      if (act >= 0 && act <= 3) begin
        if (brk) m_held[act] = 1'b0;
        else begin
          m_held[act] = 1'b1;
          if (m_dir != act) begin m_dir = act; m_chg = 1'b1; end
        end
      end else if (act == 4) begin
        if (brk) m_p_down = 1'b0;
        else if (!m_p_down) begin m_paused = !m_paused; m_p_down = 1'b1; end
      end else if (act == 5 && !brk) begin
        if (m_dir >= 0) m_chg = 1'b1;
        m_dir = -1;
      end
    end
  endtask

  function automatic logic [9:0] exp_vec();
    return {m_dir == 0, m_dir == 1, m_dir == 2, m_dir == 3, m_chg,
            m_held[0], m_held[1], m_held[2], m_held[3], m_paused};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {bus.goup, bus.godown, bus.goleft, bus.goright, bus.dir_change,
            bus.key_held, bus.paused};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, let the edge happen, update the model, compare everything
  task automatic cycle(input bit en, input logic [7:0] b, input string tag);
    bus.ps2_data_en = en;
    bus.ps2_data    = b;
    @(posedge clk);
    cyc++;
    m_chg = 1'b0;
    if (!resetn) model_clear();
    else if (en) model_byte(b);
    #1;
    bus.ps2_data_en = 1'b0;
    check(tag, 32'(obs_vec()), 32'(exp_vec()));
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    cycle(1'b1, b, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, tag);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    resetn = 1'b1;
    bus.ps2_data_en = 1'b0;
    bus.ps2_data = 8'h00;
    model_clear();
    m_last = -1000;
    #2 resetn = 1'b0;
    idle(3, "reset_hold");
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    resetn = 1'b1;
    idle(3, "reset_release");

    // W make, then typematic repeat
    send(8'h1D, "w_make");
    check("w_goup", 32'(bus.goup), 32'd1);
    check("w_pulse", 32'(bus.dir_change), 32'd1);
    check("w_held", 32'(bus.key_held), 32'h8);
    idle(1, "w_gap");
    check("w_pulse_one_cycle", 32'(bus.dir_change), 32'd0);
    send(8'h1D, "w_repeat");
    check("w_repeat_no_pulse", 32'(bus.dir_change), 32'd0);

    // Extended down make, then extended down break
    send(8'hE0, "e0_prefix");
    check("e0_no_change", 32'(bus.goup), 32'd1);
    send(8'h72, "dn_make");
    check("dn_dirs", 32'({bus.goup, bus.godown, bus.goleft, bus.goright}), 32'b0100);
    check("dn_pulse", 32'(bus.dir_change), 32'd1);
    send(8'hE0, "dn_brk_e0");
    send(8'hF0, "dn_brk_f0");
    send(8'h72, "dn_brk");
    check("dn_brk_held", 32'(bus.key_held), 32'h8);
    check("dn_brk_keeps", 32'(bus.godown), 32'd1);

    // Break of a never-pressed key, then its make
    send(8'hF0, "a_brk_f0");
    send(8'h1C, "a_brk");
    check("a_brk_no_pulse", 32'(bus.dir_change), 32'd0);
    send(8'h1C, "a_make");
    check("a_goleft", 32'({bus.goup, bus.godown, bus.goleft, bus.goright}), 32'b0010);

    // Timeout: long wait, exactly at the boundary, one past it
    send(8'hE0, "tmo_e0");
    idle(20, "tmo_wait");
    send(8'h75, "tmo_75");
    check("tmo_ignored", 32'({bus.goup, bus.dir_change}), 32'd0);
    send(8'hE0, "edge_e0");
    idle(T - 1, "edge_wait");
    send(8'h75, "edge_75");
    check("edge_ext_up", 32'({bus.goup, bus.dir_change}), 32'b11);
    send(8'hE0, "past_e0");
    idle(T, "past_wait");
    send(8'h75, "past_75");
    check("past_ignored", 32'(bus.dir_change), 32'd0);

    // Pause toggle with repeats, back-to-back strobes
    send(8'h4D, "p_make");
    check("p_on", 32'(bus.paused), 32'd1);
    send(8'h4D, "p_repeat");
    send(8'hF0, "p_brk_f0");
    send(8'h4D, "p_brk");
    check("p_brk_holds", 32'(bus.paused), 32'd1);
    send(8'h4D, "p_make2");
    check("p_off", 32'(bus.paused), 32'd0);
    send(8'h4D, "p_repeat2");
    check("p_repeat_off", 32'(bus.paused), 32'd0);

    // Esc clears a set direction once
    send(8'h23, "d_make");
    check("d_goright", 32'(bus.goright), 32'd1);
    send(8'h76, "esc");
    check("esc_clear", 32'({bus.goup, bus.godown, bus.goleft, bus.goright, bus.dir_change}), 32'b00001);
    send(8'h76, "esc_again");
    check("esc_again_no_pulse", 32'(bus.dir_change), 32'd0);

    // Reset in the middle of an extended break
    send(8'h1D, "pre_rst_w");
    send(8'hE0, "rst_e0");
    send(8'hF0, "rst_f0");
    resetn = 1'b0;
    #1;
    model_clear();
    check("rst_async", 32'(obs_vec()), 32'd0);
    idle(2, "rst_hold");
    resetn = 1'b1;
    idle(3, "rst_release");
    send(8'h23, "rst_d_make");
    check("rst_d_goright", 32'({bus.goup, bus.godown, bus.goleft, bus.goright, bus.key_held}), 32'h11);

    // Random byte streams including long gaps across the timeout
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        idle($urandom_range(T - 2, T + 2), "rnd_gap");
      end else if (r < 45) begin
        idle(1, "rnd_idle");
      end else begin
        if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
        else b = pool[$urandom_range(0, 15)];
        send(b, "rnd_byte");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_direction_ctrl.md
# ps2_direction_ctrl

Sequences the byte stream from the PS/2 controller into stable Pac-Man movement commands. Decodes make/break codes, including 0xE0-extended arrow keys and 0xF0 break prefixes, and tracks which direction keys are held. Latches the most recent direction as a one-hot command and provides pause/clear controls. Sits between the PS2_Controller instance and the game FSM.

## Interface
- TIMEOUT_CYCLES, 1000000: clock cycles a prefix state waits for its next byte before aborting (20 ms at 50 MHz); 20-bit counter.
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- ps2_data  in  8  received byte from PS2_Controller
- ps2_data_en  in  1  one-cycle strobe; ps2_data valid this cycle
- goup, godown, goleft, goright  out  1 each  latched direction command; one-hot or all zero
- dir_change  out  1  one-cycle pulse when the latched direction changes
- key_held  out  4  {up,down,left,right} currently-held physical state
- paused  out  1  pause toggle

## Operation
- Decoder FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions occur only on cycles where ps2_data_en=1, except for timeout.
- Prefix bytes:
  - 0xE0 in any state -> GOT_E0. This cancels any pending F0.
  - 0xF0 from IDLE -> GOT_F0.
  - 0xF0 from GOT_E0 -> GOT_E0F0.
  - 0xF0 in GOT_F0 or GOT_E0F0 -> no state change.
- Any other byte is decoded according to the current state, then the FSM returns to IDLE.
- Non-extended keys (IDLE = make, GOT_F0 = break): W 0x1D up, S 0x1B down, A 0x1C left, D 0x23 right, P 0x4D pause, Esc 0x76 clear.
- Extended keys (GOT_E0 = make, GOT_E0F0 = break): 0x75 up, 0x72 down, 0x6B left, 0x74 right.
- WASD and the arrow keys share key_held bits. A bit is set by either make and cleared by either break.
- Direction make:
  - Sets the key_held bit.
  - If the direction differs from the latched one: load the one-hot command and pulse dir_change.
  - A typematic repeat of the same key produces no pulse.
- Direction break: clears the key_held bit only. The latched direction persists, so Pac-Man keeps moving.
- P make: toggle paused. P break is ignored. P repeats (successive makes with no intervening break) toggle only once, tracked by an internal p_down flag cleared by P break.
- Esc make: clear all four direction outputs. Pulse dir_change if any direction was set.
- Unrecognised bytes, including 0xAA BAT, 0xFA ack and the 0xE1 sequence, are ignored and return the FSM to IDLE without changing any output.
- Timeout:
  - The counter runs only in GOT_E0, GOT_F0 and GOT_E0F0, and reloads on every accepted byte.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE with no output change.
- Reset (any time, including mid-sequence): FSM to IDLE; counter, p_down and all outputs to 0.

## Timing
- All outputs are registered. A byte strobed in cycle N is reflected on the outputs in cycle N+1. dir_change is high for exactly cycle N+1.
- Prefix bytes cause no output change.
- A complete extended make, E0 then 75, updates outputs one cycle after the second strobe.
- Strobe on the same cycle as timeout expiry: the byte wins and is decoded in the current state; the timer reloads.
- Back-to-back strobes on consecutive cycles are legal and each is processed.
- The outputs are never more than one-hot, by construction.
- Reset is asserted asynchronously and deasserted synchronously via a 2-flop synchroniser internal to the block.

## Test plan
- Reset, then strobe 0x1D: goup=1 at N+1, dir_change one pulse, key_held=4'b1000. Strobe 0x1D again: no pulse.
- Strobe E0,72: godown=1, goup=0, dir_change pulse. Then E0,F0,72: key_held[2]=0, godown stays 1.
- Strobe F0,1C (break of a key never pressed): no output change. Then 0x1C: goleft=1.
- Strobe E0 then wait TIMEOUT_CYCLES (use 16 in the bench): FSM returns to IDLE. Strobe 0x75: treated as non-extended and ignored; outputs unchanged.
- Strobe 4D,4D,F0,4D,4D: paused goes 0->1 then back to 0. Then 0x76 with goright=1: all directions 0, one dir_change pulse.
- Assert resetn=0 mid E0,F0: all outputs 0 immediately. After release, 0x23 gives goright=1.
